// File: rtl/csa_stim_checker_if.sv
// Encoder/decoder handshake bundle between the stimulus checker and the
// dual-rail adder under test.
interface csa_stim_checker_if #(
  parameter int W = 4
);
  logic [W-1:0] ax_bin;
  logic [W-1:0] bx_bin;
  logic         cx_bin;
  logic         go;
  logic         abc_e;
  logic [W-1:0] rx_sum;
  logic         rx_co;
  logic         rx_valid;

  modport master (
    output ax_bin, bx_bin, cx_bin, go,
    input  abc_e, rx_sum, rx_co, rx_valid
  );

  modport slave (
    input  ax_bin, bx_bin, cx_bin, go,
    output abc_e, rx_sum, rx_co, rx_valid
  );
endinterface

// File: rtl/csa_stim_checker.sv
// Issues a counting operand pattern to an asynchronous adder, keeps the
// expected sums in a small FIFO and scores the decoded replies.
module csa_stim_checker #(
  parameter int DIGITS = 2,
  parameter int NTOK   = 10,
  parameter int DEPTH  = 4,
  parameter int MODE   = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  csa_stim_checker_if.master   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          pass_cnt,
  output logic [15:0]          fail_cnt
);
  localparam int W  = 2 * DIGITS;
  localparam int PW = 2 * W + 1;
  localparam int EW = W + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(NTOK + 1);
  localparam logic [PW-1:0] P_INIT = (MODE == 0) ? {PW{1'b0}} : {PW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_EN, S_DRIVE, S_WAIT_ACK, S_DRAIN, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [PW-1:0] data_q, data_d;
  logic [TW-1:0] tok_q, tok_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]   pass_q, pass_d, fail_q, fail_d;
  logic          err_q, err_d;
  logic          en_s1_q, en_s2_q;
  logic          rv_s1_q, rv_s2_q, rv_s3_q;
  logic [EW-1:0] mem_q [DEPTH];

  logic          go, drive, ack, restart, push, pop;
  logic          full, empty, rv_rise, last_tok;
  logic [EW-1:0] exp_val, rx_word;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign rv_rise  = rv_s2_q & ~rv_s3_q;
  assign last_tok = (tok_q == TW'(NTOK - 1));
  assign exp_val  = EW'(p_q[W-1:0]) + EW'(p_q[2*W-1:W]) + EW'(p_q[2*W]);
  assign rx_word  = {bus.rx_co, bus.rx_sum};
  assign push     = drive;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      p_q      <= P_INIT;
      data_q   <= '0;
      tok_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      err_q    <= 1'b0;
      en_s1_q  <= 1'b0;
      en_s2_q  <= 1'b0;
      rv_s1_q  <= 1'b0;
      rv_s2_q  <= 1'b0;
      rv_s3_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      data_q   <= data_d;
      tok_q    <= tok_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      en_s1_q  <= bus.abc_e;
      en_s2_q  <= en_s1_q;
      rv_s1_q  <= bus.rx_valid;
      rv_s2_q  <= rv_s1_q;
      rv_s3_q  <= rv_s2_q;
    end
  end

  // FIFO storage needs no reset: entries are only read while non-empty.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= exp_val;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (START) state_d = S_WAIT_EN;
      S_WAIT_EN:  if (en_s2_q && !full) state_d = S_DRIVE;
      S_DRIVE:    state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (!en_s2_q) state_d = last_tok ? S_DRAIN : S_WAIT_EN;
      S_DRAIN:    if (empty) state_d = S_DONE;
      S_DONE:     if (START) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    go      = 1'b0;
    drive   = 1'b0;
    ack     = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      S_WAIT_EN:  busy = 1'b1;
      S_DRIVE:    begin busy = 1'b1; drive = 1'b1; end
      S_WAIT_ACK: begin busy = 1'b1; go = 1'b1; ack = ~en_s2_q; end
      S_DRAIN:    busy = 1'b1;
      S_DONE:     begin done = 1'b1; restart = START; end
      default:    ;
    endcase
  end

  always_comb begin
    p_d      = p_q;
    data_d   = data_q;
    tok_d    = tok_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (drive) begin
      data_d = p_q;
      p_d    = (MODE == 0) ? p_q + PW'(1) : p_q - PW'(1);
    end
    if (ack) tok_d = tok_q + TW'(1);
    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (restart) begin
      p_d   = P_INIT;
      tok_d = '0;
    end
  end

  // A reply arriving with nothing outstanding is scored as a failure.
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    err_d  = err_q;
    pop    = 1'b0;
    if (rv_rise) begin
      pop = ~empty;
      if (!empty && rx_word == mem_q[rd_ptr_q[AW-1:0]]) begin
        if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
      end else begin
        if (fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
        err_d = 1'b1;
      end
    end
    if (restart) begin
      pass_d = '0;
      fail_d = '0;
      err_d  = 1'b0;
    end
  end

  assign bus.ax_bin = data_q[W-1:0];
  assign bus.bx_bin = data_q[2*W-1:W];
  assign bus.cx_bin = data_q[2*W];
  assign bus.go     = go;
  assign err        = err_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
endmodule

// File: tb/tb_csa_stim_checker.sv
// Bench for csa_stim_checker: a behavioural encoder/decoder responder plus
// a pattern/sum reference model scoring the DUT counters.
module tb_csa_stim_checker;
  localparam int W     = 4;
  localparam int PW    = 2 * W + 1;
  localparam int EW    = W + 1;
  localparam int NTOK  = 10;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic START0 = 1'b0;
  logic START1 = 1'b0;
  logic busy0, done0, err0, busy1, done1, err1;
  logic [15:0] pass0, fail0, pass1, fail1;

  csa_stim_checker_if #(.W(W)) i0 ();
  csa_stim_checker_if #(.W(W)) i1 ();

  csa_stim_checker #(.DIGITS(2), .NTOK(NTOK), .DEPTH(DEPTH), .MODE(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .START(START0), .bus(i0.master),
    .busy(busy0), .done(done0), .err(err0), .pass_cnt(pass0), .fail_cnt(fail0)
  );

  csa_stim_checker #(.DIGITS(2), .NTOK(NTOK), .DEPTH(DEPTH), .MODE(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .START(START1), .bus(i1.master),
    .busy(busy1), .done(done1), .err(err1), .pass_cnt(pass1), .fail_cnt(fail1)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] mask;
    int          pass;
    int          fail;
    logic        err;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          resp_mode = 0;
  logic [15:0] corrupt_mask = '0;
  int          tok_base = 0;
  int          spur_cnt = 0;
  int          spur_done = 0;
  int          tok_cnt = 0;
  int          go_cnt = 0;
  int          model_pass = 0;
  int          model_fail = 0;

  function automatic logic [PW-1:0] model_p(input int idx, input int mode);
    int v;
    v = (mode == 0) ? idx : ((1 << PW) - 1 - idx);
    return PW'(v & ((1 << PW) - 1));
  endfunction

  function automatic logic [EW-1:0] model_e(input logic [PW-1:0] p);
    return EW'(p[W-1:0]) + EW'(p[2*W-1:W]) + EW'(p[2*W]);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder: drops abc_e on go, waits for go to fall, returns the sum
  // as a valid pulse, then re-arms. It is the only driver of i0 inputs.
  initial begin : responder
    logic [W-1:0]  a, b;
    logic          c;
    logic [EW-1:0] s, e;
    int            idx, lim;
    i0.abc_e = 1'b1; i0.rx_valid = 1'b0; i0.rx_sum = '0; i0.rx_co = 1'b0;
    forever begin
      @(negedge CLK);
      if (spur_cnt != spur_done) begin
        spur_done++;
        i0.rx_sum = '0; i0.rx_co = 1'b0;
        i0.rx_valid = 1'b1;
        repeat (4) @(negedge CLK);
        i0.rx_valid = 1'b0;
      end else if (!RESET && i0.go && i0.abc_e) begin
        idx = tok_cnt - tok_base;
        tok_cnt++;
        go_cnt++;
        a = i0.ax_bin; b = i0.bx_bin; c = i0.cx_bin;
        check_output("token_data", 32'({c, b, a}), 32'(model_p(idx, 0)));
        s = EW'(a) + EW'(b) + EW'(c);
        if (idx == NTOK - 1) check_output("last_sum", 32'(s), 32'h09);
        e = model_e(model_p(idx, 0));
        repeat ($urandom_range(1, 3)) @(negedge CLK);
        i0.abc_e = 1'b0;
        lim = 0;
        while (i0.go && lim < 200) begin @(negedge CLK); lim++; end
        if (lim >= 200) check_output("go_release_timeout", 32'(i0.go), 32'h0);
        if (resp_mode == 0) begin
          if (idx < 16 && corrupt_mask[idx]) begin
            s[W-1:0] = '0;
            if (e[W-1:0] == '0) model_pass++; else model_fail++;
          end else begin
            model_pass++;
          end
          repeat ($urandom_range(0, 2)) @(negedge CLK);
          i0.rx_sum = s[W-1:0]; i0.rx_co = s[W];
          @(negedge CLK);
          i0.rx_valid = 1'b1;
          repeat ($urandom_range(3, 5)) @(negedge CLK);
          i0.rx_valid = 1'b0;
        end
        repeat (3) @(negedge CLK);
        i0.abc_e = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pulse_start0();
    @(negedge CLK);
    START0 = 1'b1;
    @(negedge CLK);
    START0 = 1'b0;
  endtask

  task automatic wait_done0();
    int n = 0;
    while (!done0 && n < 3000) begin @(negedge CLK); n++; end
    if (!done0) check_output("done_timeout", 32'(done0), 32'h1);
  endtask

  // One full run of dut0 with the given corruption set; returns the model's
  // pass/fail deltas for this run.
  task automatic apply_stimulus(input logic [15:0] mask, output int dp, output int df);
    int mp, mf;
    repeat (10) @(negedge CLK);
    do_reset();
    resp_mode = 0;
    corrupt_mask = mask;
    tok_base = tok_cnt;
    mp = model_pass; mf = model_fail;
    pulse_start0();
    wait_done0();
    repeat (3) @(negedge CLK);
    dp = model_pass - mp;
    df = model_fail - mf;
  endtask

  initial begin : main
    vec_t vecs[5];
    int dp, df, g0, n;
    logic [W-1:0]  a1, b1;
    logic          c1;
    logic [EW-1:0] e1, s1;

    vecs[0] = '{mask: 16'h0000, pass: 10, fail: 0, err: 1'b0};
    vecs[1] = '{mask: 16'h0008, pass: 9,  fail: 1, err: 1'b1};
    vecs[2] = '{mask: 16'h0001, pass: 10, fail: 0, err: 1'b0};
    vecs[3] = '{mask: 16'h0200, pass: 9,  fail: 1, err: 1'b1};
    vecs[4] = '{mask: 16'h0028, pass: 8,  fail: 2, err: 1'b1};

    i1.abc_e = 1'b1; i1.rx_valid = 1'b0; i1.rx_sum = '0; i1.rx_co = 1'b0;

    #1 RESET = 1'b1;
    #1;
    check_output("reset_go",   32'(i0.go), 32'h0);
    check_output("reset_busy", 32'(busy0), 32'h0);
    check_output("reset_done", 32'(done0), 32'h0);
    check_output("reset_err",  32'(err0),  32'h0);
    check_output("reset_pass", 32'(pass0), 32'h0);
    check_output("reset_fail", 32'(fail0), 32'h0);
    check_output("reset_data", 32'({i0.cx_bin, i0.bx_bin, i0.ax_bin}), 32'h0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    spur_cnt++;
    repeat (12) @(negedge CLK);
    check_output("spur_idle_fail", 32'(fail0), 32'h1);
    check_output("spur_idle_err",  32'(err0),  32'h1);
    check_output("spur_idle_pass", 32'(pass0), 32'h0);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].mask, dp, df);
      check_output($sformatf("vec%0d_pass", i), 32'(pass0), 32'(vecs[i].pass));
      check_output($sformatf("vec%0d_fail", i), 32'(fail0), 32'(vecs[i].fail));
      check_output($sformatf("vec%0d_err", i),  32'(err0),  32'(vecs[i].err));
      check_output($sformatf("vec%0d_done", i), 32'(done0), 32'h1);
      check_output($sformatf("vec%0d_busy", i), 32'(busy0), 32'h0);
      check_output($sformatf("vec%0d_model_pass", i), 32'(pass0), 32'(dp));
    end

    for (int r = 0; r < 3; r++) begin
      apply_stimulus(16'($urandom() & 32'h3FF), dp, df);
      check_output($sformatf("rand%0d_pass", r), 32'(pass0), 32'(dp));
      check_output($sformatf("rand%0d_fail", r), 32'(fail0), 32'(df));
      check_output($sformatf("rand%0d_err", r),  32'(err0),  32'(df != 0));
    end

    repeat (10) @(negedge CLK);
    resp_mode = 1;
    do_reset();
    g0 = go_cnt;
    tok_base = tok_cnt;
    pulse_start0();
    repeat (400) @(negedge CLK);
    check_output("full_go_pulses", 32'(go_cnt - g0), 32'(DEPTH));
    check_output("full_go_low",    32'(i0.go), 32'h0);
    check_output("full_busy",      32'(busy0), 32'h1);
    check_output("full_done",      32'(done0), 32'h0);

    do_reset();
    tok_base = tok_cnt;
    pulse_start0();
    n = 0;
    while (!i0.go && n < 200) begin @(negedge CLK); n++; end
    check_output("abort_go_seen", 32'(i0.go), 32'h1);
    #2 RESET = 1'b1;
    #1;
    check_output("abort_go_async",   32'(i0.go), 32'h0);
    check_output("abort_busy_async", 32'(busy0), 32'h0);
    check_output("abort_data_async", 32'({i0.cx_bin, i0.bx_bin, i0.ax_bin}), 32'h0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (20) @(negedge CLK);
    resp_mode = 0;
    corrupt_mask = '0;
    tok_base = tok_cnt;
    dp = model_pass;
    pulse_start0();
    wait_done0();
    repeat (3) @(negedge CLK);
    check_output("restart_pass", 32'(pass0), 32'(model_pass - dp));
    check_output("restart_fail", 32'(fail0), 32'h0);

    do_reset();
    @(negedge CLK);
    START1 = 1'b1;
    @(negedge CLK);
    START1 = 1'b0;
    n = 0;
    while (!i1.go && n < 200) begin @(negedge CLK); n++; end
    a1 = i1.ax_bin; b1 = i1.bx_bin; c1 = i1.cx_bin;
    check_output("mode1_first_token", 32'({c1, b1, a1}), 32'(model_p(0, 1)));
    s1 = EW'(a1) + EW'(b1) + EW'(c1);
    check_output("mode1_sum", 32'(s1), 32'h1F);
    i1.abc_e = 1'b0;
    n = 0;
    while (i1.go && n < 200) begin @(negedge CLK); n++; end
    e1 = model_e(model_p(0, 1));
    i1.rx_sum = e1[W-1:0]; i1.rx_co = e1[W];
    @(negedge CLK);
    i1.rx_valid = 1'b1;
    repeat (4) @(negedge CLK);
    i1.rx_valid = 1'b0;
    repeat (6) @(negedge CLK);
    check_output("mode1_pass", 32'(pass1), 32'h1);
    check_output("mode1_fail", 32'(fail1), 32'h0);
    check_output("mode1_err",  32'(err1),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/csa_stim_checker.md
CSA_STIM_CHECKER -- requirements
Module: csa_stim_checker

Interface
REQ-001 Parameter DIGITS, default 2, number of 1-of-4 digits per operand; operand width W = 2*DIGITS.
REQ-002 Parameter NTOK, default 10, number of tokens issued per run.
REQ-003 Parameter DEPTH, default 4, expected-result FIFO depth (power of two, >= 2).
REQ-004 Parameter MODE, default 0; 0 = incrementing pattern, 1 = decrementing pattern.
REQ-005 CLK  in  1  sole clock; all state changes on rising edge.
REQ-006 RESET  in  1  reset, asynchronous and active-high.
REQ-007 START  in  1  single-cycle run request.
REQ-008 ax_bin, bx_bin  out  W  binary operands A and B for the 1-of-4 encoders.
REQ-009 cx_bin  out  1  binary carry-in for the 1-of-2 encoder.
REQ-010 go  out  1  token-valid request to encoders.
REQ-011 abc_e  in  1  DUT input enable, asynchronous; high = ready.
REQ-012 rx_sum  in  W  decoded sum; rx_co  in  1  decoded carry-out.
REQ-013 rx_valid  in  1  decoder valid, asynchronous; high = sum and carry both valid.
REQ-014 busy, done, err  out  1 each  run active, run complete, sticky mismatch flag.
REQ-015 pass_cnt, fail_cnt  out  16 each  result counters.

Function
REQ-016 abc_e and rx_valid SHALL each pass through a 2-flop synchroniser before use; all references below are to the synchronised versions.
REQ-017 Pattern register P, 2W+1 bits: A = P[W-1:0], B = P[2W-1:W], C = P[2W].
- MODE 0: P starts at 0 and increments by 1 per token.
- MODE 1: P starts at all-ones and decrements by 1 per token.
- P wraps modulo 2^(2W+1).
REQ-018 Source FSM states: IDLE, WAIT_EN, DRIVE, WAIT_ACK, DRAIN, DONE.
REQ-019 IDLE -> WAIT_EN on START; START is ignored in every other state.
REQ-020 WAIT_EN -> DRIVE when abc_e = 1 and FIFO not full; otherwise hold with go = 0.
REQ-021 DRIVE, one cycle:
- register ax_bin/bx_bin/cx_bin from P;
- set go = 1;
- push expected E = A + B + C (W+1 bits) into FIFO;
- advance P;
- go to WAIT_ACK.
REQ-022 WAIT_ACK: hold go and data until abc_e = 0, then clear go in that cycle and increment the token count. Next state is WAIT_EN if tokens sent < NTOK, else DRAIN.
REQ-023 DRAIN -> DONE when FIFO is empty; DONE -> IDLE on START, clearing done and counters and reloading P.
REQ-024 Checker: on a rising edge of rx_valid, sample {rx_co, rx_sum} and compare with the FIFO head.
- Match: pop, pass_cnt + 1.
- Mismatch: pop, fail_cnt + 1, err = 1.
- Counters update one cycle after the edge is detected.
REQ-025 An rx_valid rising edge with the FIFO empty SHALL increment fail_cnt, set err, and leave the FIFO unchanged.
REQ-026 A simultaneous push and pop SHALL be permitted in the same cycle; occupancy is unchanged.
REQ-027 Counters SHALL saturate at 16'hFFFF.
REQ-028 busy = 1 in WAIT_EN, DRIVE, WAIT_ACK and DRAIN; done = 1 only in DONE.

Reset
REQ-029 While RESET = 1, all outputs SHALL be held at the following values, asynchronously:
- go = 0, ax_bin = bx_bin = cx_bin = 0;
- busy = done = err = 0;
- pass_cnt = fail_cnt = 0.
REQ-030 RESET SHALL also empty the FIFO, return the FSM to IDLE, reload P per MODE, clear the token count and clear the synchronisers.
REQ-031 RESET asserted mid-run SHALL abort the run with no partial counting; the next START begins from token 0.

Verification
REQ-032 Reset: assert RESET with DUT idle -> go = 0, all counters 0, done = 0, busy = 0 immediately, without a clock edge.
REQ-033 Ideal responder, DIGITS = 2, NTOK = 10, MODE 0 -> tokens A = 0..9 with B = C = 0; last expected value is 5'b01001; ends with pass_cnt = 10, fail_cnt = 0, err = 0, done = 1.
REQ-034 Responder corrupts token 3 (returns sum 4'b0000) -> fail_cnt = 1, pass_cnt = 9, err = 1, done = 1.
REQ-035 Responder never raises rx_valid, DEPTH = 4 -> exactly 4 go pulses, then the FSM stays in WAIT_EN with go = 0 and busy = 1.
REQ-036 MODE 1, DIGITS = 2 -> first token A = 15, B = 15, C = 1; expected {co, sum} = 5'b11111; a correct reply gives pass_cnt = 1.
REQ-037 Two spurious cases:
- rx_valid pulse while in IDLE -> fail_cnt = 1, err = 1.
- RESET asserted while go = 1 -> go falls without a clock edge; after START the first token again has P = 0.
